// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM bundle and drives the register file write port,
// the difftest commit record, the cycle/instret counters and the simulation-trap halt.
module wb_stage #(
  parameter int          XLEN      = 64,
  parameter logic [31:0] TRAP_INST = 32'h0000006b
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_wen,
  input  logic [XLEN-1:0] in_rd_data,
  input  logic            in_skip,
  input  logic [XLEN-1:0] rf_a0,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            rf_wen,
  output logic            cmt_valid,
  output logic [XLEN-1:0] cmt_pc,
  output logic [31:0]     cmt_inst,
  output logic            cmt_skip,
  output logic            cmt_wen,
  output logic [4:0]      cmt_wdest,
  output logic [XLEN-1:0] cmt_wdata,
  output logic            trap_valid,
  output logic [7:0]      trap_code,
  output logic            halted,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_pc_q, wb_pc_d;
  logic [31:0]     wb_inst_q, wb_inst_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_rd_wen_q, wb_rd_wen_d;
  logic [XLEN-1:0] wb_rd_data_q, wb_rd_data_d;
  logic            wb_skip_q, wb_skip_d;
  logic [63:0]     cycle_cnt_q, cycle_cnt_d;
  logic [63:0]     instret_cnt_q, instret_cnt_d;

  logic            wb_is_trap;
  logic            accept;
  logic            wen_eff;
  logic            unused_a0_hi;

  assign unused_a0_hi = ^rf_a0[XLEN-1:8];

  // The bundle behind a committing trap is held off so it can never retire.
  always_comb begin
    wb_is_trap   = wb_valid_q && (wb_inst_q == TRAP_INST);
    in_ready     = (state_q == ST_RUN) && !wb_is_trap;
    accept       = in_valid && in_ready;

    wb_valid_d   = 1'b0;
    wb_pc_d      = wb_pc_q;
    wb_inst_d    = wb_inst_q;
    wb_rd_d      = wb_rd_q;
    wb_rd_wen_d  = wb_rd_wen_q;
    wb_rd_data_d = wb_rd_data_q;
    wb_skip_d    = wb_skip_q;
    if (accept) begin
      wb_valid_d   = 1'b1;
      wb_pc_d      = in_pc;
      wb_inst_d    = in_inst;
      wb_rd_d      = in_rd;
      wb_rd_wen_d  = in_rd_wen;
      wb_rd_data_d = in_rd_data;
      wb_skip_d    = in_skip;
    end

    state_d = state_q;
    if ((state_q == ST_RUN) && wb_is_trap) begin
      state_d = ST_HALT;
    end

    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q == ST_RUN) begin
      cycle_cnt_d = cycle_cnt_q + 64'd1;
    end
    if (wb_valid_q) begin
      instret_cnt_d = instret_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wb_valid_q    <= 1'b0;
      wb_pc_q       <= '0;
      wb_inst_q     <= '0;
      wb_rd_q       <= '0;
      wb_rd_wen_q   <= 1'b0;
      wb_rd_data_q  <= '0;
      wb_skip_q     <= 1'b0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wb_valid_q    <= wb_valid_d;
      wb_pc_q       <= wb_pc_d;
      wb_inst_q     <= wb_inst_d;
      wb_rd_q       <= wb_rd_d;
      wb_rd_wen_q   <= wb_rd_wen_d;
      wb_rd_data_q  <= wb_rd_data_d;
      wb_skip_q     <= wb_skip_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  // x0 writes still commit but never reach the register file.
  assign wen_eff     = wb_valid_q && wb_rd_wen_q && (wb_rd_q != 5'd0);

  assign rf_wen      = wen_eff;
  assign rf_waddr    = wb_rd_q;
  assign rf_wdata    = wb_rd_data_q;

  assign cmt_valid   = wb_valid_q;
  assign cmt_pc      = wb_pc_q;
  assign cmt_inst    = wb_inst_q;
  assign cmt_skip    = wb_skip_q;
  assign cmt_wen     = wen_eff;
  assign cmt_wdest   = wb_rd_q;
  assign cmt_wdata   = wen_eff ? wb_rd_data_q : '0;

  assign trap_valid  = wb_is_trap;
  assign trap_code   = rf_a0[7:0];
  assign halted      = (state_q == ST_HALT);
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a transaction-level model predicts each cycle's outputs,
// a driver queues the predictions and a negedge monitor compares them against the DUT.
module tb_wb_stage;

  localparam logic [31:0] TRAP = 32'h0000006b;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [63:0] in_rd_data;
  logic        in_skip;
  logic [63:0] rf_a0;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        rf_wen;
  logic        cmt_valid;
  logic [63:0] cmt_pc;
  logic [31:0] cmt_inst;
  logic        cmt_skip;
  logic        cmt_wen;
  logic [4:0]  cmt_wdest;
  logic [63:0] cmt_wdata;
  logic        trap_valid;
  logic [7:0]  trap_code;
  logic        halted;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  wb_stage #(.XLEN(64), .TRAP_INST(TRAP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_rd_data(in_rd_data), .in_skip(in_skip), .rf_a0(rf_a0),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst), .cmt_skip(cmt_skip),
    .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata),
    .trap_valid(trap_valid), .trap_code(trap_code), .halted(halted),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] data;
    logic        skip;
  } bundle_t;

  // One prediction per cycle; 'commit' is the instruction the model says retires that cycle.
  typedef struct packed {
    logic        chk;
    logic        fresh;
    logic        ready;
    bundle_t     commit;
    logic [7:0]  code;
    logic        halt;
    logic [63:0] cyc;
    logic [63:0] ret;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_wen;

  int checks = 0;
  int errors = 0;

  // Model state: retiring instruction, halt flag, counters.
  bundle_t     m_commit;
  logic        m_known  = 1'b0;
  logic        m_fresh  = 1'b0;
  logic        m_halted = 1'b0;
  logic [63:0] m_cyc    = '0;
  logic [63:0] m_ret    = '0;

  function automatic bundle_t mk(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                                 input logic [4:0] rd, input logic wen, input logic [63:0] data,
                                 input logic skip);
    bundle_t b;
    b.valid = v; b.pc = pc; b.inst = inst; b.rd = rd; b.wen = wen; b.data = data; b.skip = skip;
    return b;
  endfunction

  function automatic bundle_t idle();
    return mk(1'b0, 64'h0, 32'h13, 5'd0, 1'b0, 64'h0, 1'b0);
  endfunction

  function automatic bundle_t randBundle(input int pct);
    bundle_t b;
    b.valid = ($urandom_range(99) < pct);
    b.pc    = {$urandom, $urandom};
    b.inst  = $urandom;
    if (b.inst == TRAP) b.inst = b.inst ^ 32'h1;
    b.rd    = 5'($urandom_range(31));
    b.wen   = 1'($urandom_range(1));
    b.data  = {$urandom, $urandom};
    b.skip  = ($urandom_range(3) == 0);
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle, push the model's prediction for it, then advance the model past the edge.
  task automatic applyStimulus(input logic r, input bundle_t b, input logic [63:0] a0);
    exp_t e;
    logic acc;
    @(posedge clk);
    #1;
    rst        = r;
    in_valid   = b.valid;
    in_pc      = b.pc;
    in_inst    = b.inst;
    in_rd      = b.rd;
    in_rd_wen  = b.wen;
    in_rd_data = b.data;
    in_skip    = b.skip;
    rf_a0      = a0;

    e.chk    = !r && m_known;
    e.fresh  = m_fresh;
    e.ready  = !m_halted && !(m_commit.valid && m_commit.inst == TRAP);
    e.commit = m_commit;
    e.code   = a0[7:0];
    e.halt   = m_halted;
    e.cyc    = m_cyc;
    e.ret    = m_ret;
    exp_q.push_back(e);

    if (r) begin
      m_commit = mk(1'b0, 64'h0, 32'h0, 5'd0, 1'b0, 64'h0, 1'b0);
      m_known  = 1'b1;
      m_fresh  = 1'b1;
      m_halted = 1'b0;
      m_cyc    = '0;
      m_ret    = '0;
    end else begin
      acc = b.valid && e.ready;
      if (!m_halted) m_cyc = m_cyc + 64'd1;
      if (m_commit.valid) m_ret = m_ret + 64'd1;
      if (m_commit.valid && m_commit.inst == TRAP) m_halted = 1'b1;
      m_commit       = b;
      m_commit.valid = acc;
      m_fresh        = 1'b0;
    end
  endtask

  // Monitor: consume one prediction per cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk) begin
        mon_wen = mon_e.commit.valid && mon_e.commit.wen && (mon_e.commit.rd != 5'd0);
        checkOutput("in_ready", in_ready, mon_e.ready);
        checkOutput("cmt_valid", cmt_valid, mon_e.commit.valid);
        checkOutput("rf_wen", rf_wen, mon_wen);
        checkOutput("cmt_wen", cmt_wen, mon_wen);
        checkOutput("cmt_wdata", cmt_wdata, mon_wen ? mon_e.commit.data : 64'h0);
        checkOutput("trap_valid", trap_valid,
                    mon_e.commit.valid && (mon_e.commit.inst == TRAP));
        checkOutput("trap_code", trap_code, mon_e.code);
        checkOutput("halted", halted, mon_e.halt);
        checkOutput("cycle_cnt", cycle_cnt, mon_e.cyc);
        checkOutput("instret_cnt", instret_cnt, mon_e.ret);
        if (mon_e.commit.valid || mon_e.fresh) begin
          checkOutput("cmt_pc", cmt_pc, mon_e.commit.pc);
          checkOutput("cmt_inst", cmt_inst, mon_e.commit.inst);
          checkOutput("cmt_skip", cmt_skip, mon_e.commit.skip);
          checkOutput("cmt_wdest", cmt_wdest, mon_e.commit.rd);
          checkOutput("rf_waddr", rf_waddr, mon_e.commit.rd);
          checkOutput("rf_wdata", rf_wdata, mon_e.commit.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_rd = '0;
    in_rd_wen = 1'b0; in_rd_data = '0; in_skip = 1'b0; rf_a0 = '0;

    $display("[TB] reset and idle");
    applyStimulus(1'b1, idle(), 64'h0);
    applyStimulus(1'b1, idle(), 64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, idle(), 64'h0);

    $display("[TB] back-to-back stream");
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b0, mk(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h0000_0093, 5'(i), 1'b1,
                             64'(16 * i), 1'b0), 64'h0);
    applyStimulus(1'b0, idle(), 64'h0);

    $display("[TB] write to x0");
    applyStimulus(1'b0, mk(1'b1, 64'h8000_0100, 32'h0000_0013, 5'd0, 1'b1, 64'hdead, 1'b0), 64'h0);
    applyStimulus(1'b0, idle(), 64'h0);

    $display("[TB] bubble and skip");
    applyStimulus(1'b0, mk(1'b1, 64'h8000_0200, 32'h0000_0113, 5'd2, 1'b1, 64'h55, 1'b0), 64'h0);
    applyStimulus(1'b0, idle(), 64'h0);
    applyStimulus(1'b0, mk(1'b1, 64'h8000_0208, 32'h0000_3183, 5'd3, 1'b1, 64'h66, 1'b1), 64'h0);
    applyStimulus(1'b0, idle(), 64'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, randBundle(70), {$urandom, $urandom});

    $display("[TB] trap with a held bundle behind it");
    applyStimulus(1'b0, mk(1'b1, 64'h8000_0300, TRAP, 5'd0, 1'b0, 64'h0, 1'b0), 64'h0);
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b0, mk(1'b1, 64'h8000_0304, 32'h0000_0293, 5'd5, 1'b1, 64'hbeef, 1'b0),
                    (i < 2) ? 64'h0 : {$urandom, $urandom});

    $display("[TB] reset out of halt, then reset right after an accept");
    applyStimulus(1'b1, idle(), 64'h0);
    applyStimulus(1'b0, idle(), 64'h0);
    applyStimulus(1'b0, idle(), 64'h0);
    applyStimulus(1'b0, mk(1'b1, 64'h8000_0400, 32'h0000_0393, 5'd7, 1'b1, 64'h777, 1'b0), 64'h0);
    applyStimulus(1'b1, mk(1'b1, 64'h8000_0404, 32'h0000_0493, 5'd9, 1'b1, 64'h999, 1'b0), 64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, idle(), 64'h0);

    $display("[TB] random traffic with traps at random points");
    for (int ep = 0; ep < 3; ep++) begin
      int trap_at;
      bundle_t b;
      trap_at = $urandom_range(5, 25);
      applyStimulus(1'b1, idle(), 64'h0);
      for (int i = 0; i < 40; i++) begin
        b = randBundle(80);
        if (i == trap_at) begin
          b.valid = 1'b1;
          b.inst  = TRAP;
        end
        applyStimulus(1'b0, b, {$urandom, $urandom});
      end
    end

    repeat (2) @(negedge clk);
    #2;
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
